pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It merges stall requests from the ID, EX and MEM stages into one per-stage stall vector that drives pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb). It also sequences exception flushes, deferring them while memory is busy. It keeps a saturating stall-cycle counter and a stall watchdog for debug.

Parameters:
WD_MAX, 1023, consecutive stall cycles at which hang asserts (1..65535)
HOLDOFF, 1, cycles after a flush during which excp_req is ignored (1..7)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
stallreq_id  input  1  ID stage requests a stall (load-use hazard)
stallreq_ex  input  1  EX stage requests a stall (multi-cycle op)
stallreq_mem  input  1  MEM stage requests a stall (memory wait)
excp_req  input  1  exception or trap taken in MEM, level
excp_target  input  32  handler PC, valid with excp_req
stall  output  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (0)
flush  output  1  registered one-cycle pulse clearing all pipeline registers
new_pc  output  32  registered redirect PC, valid while flush=1
stall_cnt  output  32  total cycles with stall[0]=1, saturating
hang  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=RUN, flush=0, new_pc=0x00000000, stall_cnt=0, hang=0, pending target cleared, watchdog counter=0, holdoff counter=0.
- stall is combinational from the inputs and the current state, with zero latency, so pipeline registers freeze in the same cycle as the request.
  - Priority is MEM > EX > ID.
  - stallreq_mem gives 6'b011111.
  - stallreq_ex gives 6'b001111.
  - stallreq_id gives 6'b000111.
  - No request gives 6'b000000.
  - In state FLUSH, stall is forced to 0.
- States: RUN, WAIT_MEM, FLUSH, HOLD.
- RUN:
  - excp_req=1 and stallreq_mem=0: load new_pc<=excp_target, go to FLUSH. flush=1 in the next cycle.
  - excp_req=1 and stallreq_mem=1: latch excp_target into the pending register, go to WAIT_MEM.
- WAIT_MEM:
  - Stalls are passed through normally.
  - Further excp_req is ignored; the first exception wins.
  - On the first cycle with stallreq_mem=0: new_pc<=pending, go to FLUSH.
- FLUSH: lasts exactly one cycle. flush=1, stall=0. Then go to HOLD and load the holdoff counter with HOLDOFF.
- HOLD:
  - excp_req is ignored (it comes from stale flushed state).
  - Stalls are passed through.
  - The counter decrements each cycle; at 0, return to RUN.
- new_pc holds its last value after flush drops.
- stall_cnt: +1 every cycle with stall[0]=1. It holds at 0xFFFFFFFF and never wraps.
- Watchdog:
  - A 16-bit consecutive counter increments while stall[0]=1 and clears when stall[0]=0.
  - When the count reaches WD_MAX, hang<=1.
  - hang stays set until reset. The counter saturates at WD_MAX.
- FLUSH cycles count as non-stall: stall_cnt does not increment and the watchdog counter clears.
- Reset asserted mid-WAIT_MEM or mid-FLUSH aborts immediately: the pending exception is lost and no flush is issued after reset release.

Test Plan:
- Priority: drive stallreq_id=1, stallreq_ex=1, stallreq_mem=0 in the same cycle -> stall=6'b001111. Then drive only stallreq_id -> stall=6'b000111. stall_cnt increments by 2.
- Immediate flush: in RUN, excp_req=1, excp_target=0x00000020, no stalls -> next cycle flush=1 and new_pc=0x00000020 for exactly 1 cycle. With HOLDOFF=1, excp_req held high is ignored for 1 cycle, so the second flush comes 3 cycles after the first.
- Deferred flush: excp_req=1 (target 0x80000180) while stallreq_mem=1 for 4 cycles -> flush=0 and stall=6'b011111 throughout. The cycle after stallreq_mem drops, flush=1 and new_pc=0x80000180. A second excp_req with target 0x1 during the wait is ignored.
- Stall suppression: stallreq_ex=1 held during the FLUSH cycle -> stall=0 in that cycle and 6'b001111 in the next. stall_cnt is not incremented for the FLUSH cycle.
- Watchdog: WD_MAX=8, stallreq_id held 7 cycles then dropped -> hang=0. Then held 8 cycles -> hang=1, and it stays 1 after the stall clears.
- Reset mid-operation: rst low during WAIT_MEM -> flush=0, new_pc=0, stall_cnt=0, hang=0 immediately (async). No flush after release even with stallreq_mem=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stage stall requests into a per-stage stall
// vector, sequences exception flushes (deferred while memory is busy) and tracks stall debug counters.
module pipe_ctrl #(
  parameter int unsigned WD_MAX  = 1023,
  parameter int unsigned HOLDOFF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        hang
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_MEM,
    S_FLUSH,
    S_HOLD
  } state_t;

  localparam logic [15:0] WD_LIMIT   = 16'(WD_MAX);
  localparam logic [2:0]  HOLD_CYCLES = 3'(HOLDOFF);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pending;
  logic [31:0] r_new_pc;
  logic [31:0] r_stall_cnt;
  logic [15:0] r_wd_cnt;
  logic [2:0]  r_hold_cnt;
  logic        r_flush;
  logic        r_hang;
  logic [5:0]  w_stall;
  logic        w_pc_stall;

  // NOTE: every flop here, including the pending-target register, has an async
  // reset so an exception caught mid-sequence is fully discarded by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    // NOTE: sequential state always uses non-blocking assignment.
    else      r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_RUN:      if (excp_req) w_next = stallreq_mem ? S_WAIT_MEM : S_FLUSH;
      S_WAIT_MEM: if (!stallreq_mem) w_next = S_FLUSH;
      S_FLUSH:    w_next = S_HOLD;
      S_HOLD:     if (r_hold_cnt <= 3'd1) w_next = S_RUN;
      default:    w_next = S_RUN;
    endcase
  end

  // Stall freezes the requesting stage and every stage upstream of it.
  always_comb begin
    w_stall = 6'b000000;
    if (r_state != S_FLUSH) begin
      if (stallreq_mem)     w_stall = 6'b011111;
      else if (stallreq_ex) w_stall = 6'b001111;
      else if (stallreq_id) w_stall = 6'b000111;
    end
  end

  assign w_pc_stall = w_stall[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= 32'h0;
      r_new_pc   <= 32'h0;
      r_flush    <= 1'b0;
      r_hold_cnt <= 3'd0;
    end else begin
      r_flush <= (w_next == S_FLUSH);
      if (r_state == S_RUN && excp_req) begin
        if (stallreq_mem) r_pending <= excp_target;
        else              r_new_pc  <= excp_target;
      end
      if (r_state == S_WAIT_MEM && !stallreq_mem) r_new_pc <= r_pending;
      if (r_state == S_FLUSH)                       r_hold_cnt <= HOLD_CYCLES;
      else if (r_state == S_HOLD && r_hold_cnt != 3'd0) r_hold_cnt <= r_hold_cnt - 3'd1;
    end
  end

  // Debug counters: lifetime stall total and a consecutive-stall watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'h0;
      r_wd_cnt    <= 16'h0;
      r_hang      <= 1'b0;
    end else if (w_pc_stall) begin
      if (r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (r_wd_cnt != WD_LIMIT) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
        if (r_wd_cnt + 16'd1 == WD_LIMIT) r_hang <= 1'b1;
      end
    end else begin
      r_wd_cnt <= 16'h0;
    end
  end

  assign stall     = w_stall;
  assign flush     = r_flush;
  assign new_pc    = r_new_pc;
  assign stall_cnt = r_stall_cnt;
  assign hang      = r_hang;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// compared every cycle against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned WD_MAX  = 8;
  localparam int unsigned HOLDOFF = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_target = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic        hang;

  int checks = 0;
  int failures = 0;

  // Reference model state, expressed as the rules describe it.
  bit          m_flush_now;
  bit          m_waiting;
  logic [31:0] m_pend;
  int          m_ignore_left;
  logic [31:0] m_new_pc;
  logic [31:0] m_cnt;
  int          m_run;
  bit          m_hang;

  pipe_ctrl #(.WD_MAX(WD_MAX), .HOLDOFF(HOLDOFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excp_req    (excp_req),
    .excp_target (excp_target),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .stall_cnt   (stall_cnt),
    .hang        (hang)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_now   = 0;
    m_waiting     = 0;
    m_pend        = 32'h0;
    m_ignore_left = 0;
    m_new_pc      = 32'h0;
    m_cnt         = 32'h0;
    m_run         = 0;
    m_hang        = 0;
  endtask

  function automatic logic [5:0] exp_stall(input bit id, input bit ex, input bit mem);
    if (m_flush_now) return 6'b000000;
    if (mem)         return 6'b011111;
    if (ex)          return 6'b001111;
    if (id)          return 6'b000111;
    return 6'b000000;
  endfunction

  // One clock: drive inputs, compare every output, then advance the model.
  task automatic step(input bit id, input bit ex, input bit mem, input bit exc,
                      input logic [31:0] tgt);
    logic [5:0] es;
    @(negedge clk);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excp_req     = exc;
    excp_target  = tgt;
    #1;
    es = exp_stall(id, ex, mem);
    check("stall", {26'h0, stall}, {26'h0, es});
    check("flush", {31'h0, flush}, {31'h0, m_flush_now});
    check("new_pc", new_pc, m_new_pc);
    check("stall_cnt", stall_cnt, m_cnt);
    check("hang", {31'h0, hang}, {31'h0, m_hang});
    @(posedge clk);
    if (m_flush_now) begin
      m_flush_now   = 0;
      m_ignore_left = HOLDOFF;
      m_run         = 0;
    end else begin
      if (es[0]) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_run++;
        if (m_run >= WD_MAX) m_hang = 1;
      end else begin
        m_run = 0;
      end
      if (m_ignore_left > 0) begin
        m_ignore_left--;
      end else if (m_waiting) begin
        if (!mem) begin
          m_waiting   = 0;
          m_flush_now = 1;
          m_new_pc    = m_pend;
        end
      end else if (exc) begin
        if (mem) begin
          m_waiting = 1;
          m_pend    = tgt;
        end else begin
          m_flush_now = 1;
          m_new_pc    = tgt;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst          = 1'b0;
    stallreq_id  = 0;
    stallreq_ex  = 0;
    stallreq_mem = 0;
    excp_req     = 0;
    #1;
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_hang", {31'h0, hang}, 32'h0);
    check("rst_stall", {26'h0, stall}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] base;
    model_reset();
    apply_reset();

    // Priority: EX over ID, then ID alone; two counted stall cycles.
    base = m_cnt;
    step(1, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    #1 check("prio_cnt", stall_cnt, base + 32'd2);
    idle(2);

    // Immediate flush, then excp_req held: second flush three cycles later.
    step(0, 0, 0, 1, 32'h0000_0020);
    #1 check("imm_flush", {31'h0, flush}, 32'h1);
    check("imm_new_pc", new_pc, 32'h0000_0020);
    step(0, 0, 0, 1, 32'h0000_0020);
    #1 check("imm_flush_drop", {31'h0, flush}, 32'h0);
    step(0, 0, 0, 1, 32'h0000_0020);
    step(0, 0, 0, 1, 32'h0000_0020);
    #1 check("imm_second_flush", {31'h0, flush}, 32'h1);
    idle(4);

    // Deferred flush behind a memory wait; a later exception is ignored.
    step(0, 0, 1, 1, 32'h8000_0180);
    step(0, 0, 1, 1, 32'h0000_0001);
    step(0, 0, 1, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    #1 check("def_no_flush", {31'h0, flush}, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    #1 check("def_flush", {31'h0, flush}, 32'h1);
    check("def_new_pc", new_pc, 32'h8000_0180);

    // Stall suppressed during the FLUSH cycle and not counted.
    base = m_cnt;
    step(0, 1, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    #1 check("supp_cnt", stall_cnt, base + 32'd1);
    idle(3);

    // Watchdog: 7 consecutive stalls stay quiet, 8 trip it and it sticks.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    #1 check("wd_below", {31'h0, hang}, 32'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 32'h0);
    idle(3);
    #1 check("wd_sticky", {31'h0, hang}, 32'h1);

    // Reset during WAIT_MEM discards the pending exception.
    step(0, 0, 1, 1, 32'h0000_4444);
    step(0, 0, 1, 0, 32'h0);
    apply_reset();
    idle(4);
    #1 check("rst_no_flush_pc", new_pc, 32'h0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) apply_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
